// File: rtl/xor_fold_pkg.sv
// Shared types and helpers for the lane-wise XOR fold accumulator.
// rotl1 rotates the low w bits of v left by one; bits at and above w stay zero.
package xor_fold_pkg;

    typedef enum logic {ACC, OUT} state_t;

    localparam int MAX_WIDTH = 64;
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    function automatic logic [MAX_WIDTH-1:0] rotl1(input logic [MAX_WIDTH-1:0] v,
                                                   input int unsigned         w);
        logic [MAX_WIDTH-1:0] r;
        logic [IDX_W-1:0]     top;
        r    = '0;
        top  = IDX_W'(w - 1);
        r[0] = v[top];
        for (int i = 1; i < MAX_WIDTH; i++) begin
            if (i < w) r[i] = v[i-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/xor_fold_acc.sv
// Folds BEATS accepted beats into one result by lane-wise XOR (rotate-left-by-1 before each XOR under XOR_FOLD_ROTATE_EN).
// Result valid the cycle after the final beat; held until out_ready, during which in_ready is low.
module xor_fold_acc
    import xor_fold_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int               CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] folded;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign in_ready = (state == ACC);
    assign accept   = in_valid && in_ready;

    always_comb begin
        folded = '0;
`ifdef XOR_FOLD_ROTATE_EN
        folded = WIDTH'(rotl1(MAX_WIDTH'(acc), WIDTH)) ^ in_data;
`else
        folded = acc ^ in_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    // A beat arriving with flush completes its handshake but is dropped.
                    if (flush) begin
                        acc <= '0;
                        cnt <= '0;
                    end else if (accept) begin
                        if (cnt == LAST) begin
                            out_data  <= folded;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end else begin
                            acc <= folded;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_fold_acc.sv
// Randomized and directed bench for xor_fold_acc (WIDTH=4/BEATS=4 plus a WIDTH=1/BEATS=2 instance).
module tb_xor_fold_acc;

`ifdef XOR_FOLD_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;

    logic       flush1;
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] in_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic [0:0] out_data1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: list of beats since the last clear, folded when BEATS are present.
    logic [3:0] beats_q[$];
    bit         m_busy;
    logic [3:0] m_out;

    xor_fold_acc #(.WIDTH(4), .BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    xor_fold_acc #(.WIDTH(1), .BEATS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mix(input logic [3:0] x);
        int v;
        v = int'(x);
        if (ROT) v = ((v * 2) % 16) + (v / 8);
        return 4'(v);
    endfunction

    function automatic logic [3:0] fold_q();
        logic [3:0] r;
        r = 4'h0;
        foreach (beats_q[i]) r = mix(r) ^ beats_q[i];
        return r;
    endfunction

    task automatic model_reset();
        beats_q.delete();
        m_busy = 1'b0;
        m_out  = 4'h0;
    endtask

    task automatic step(input bit v, input logic [3:0] d, input bit f, input bit r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        if (m_busy) begin
            if (r) m_busy = 1'b0;
        end else if (f) begin
            beats_q.delete();
        end else if (v) begin
            beats_q.push_back(d);
            if (beats_q.size() == 4) begin
                m_out = fold_q();
                beats_q.delete();
                m_busy = 1'b1;
            end
        end
        @(negedge clk);
        chk("in_ready",  32'(in_ready),  32'(!m_busy));
        chk("out_valid", 32'(out_valid), 32'(m_busy));
        chk("out_data",  32'(out_data),  32'(m_out));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_w1_valid"},  32'(out_valid1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] d;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
        flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 1'b0; out_ready1 = 1'b1;
        model_reset();
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain fold back-to-back, one-cycle valid pulse
        step(1, 4'h1, 0, 1); step(1, 4'h2, 0, 1); step(1, 4'h4, 0, 1);
        chk("fold_not_early", 32'(out_valid), 32'd0);
        step(1, 4'h8, 0, 1);
        chk("fold_1248", 32'(out_data), ROT ? 32'h0 : 32'hF);
        chk("fold_1248_valid", 32'(out_valid), 32'd1);
        step(0, 4'h0, 0, 1);
        chk("valid_one_cycle", 32'(out_valid), 32'd0);

        // Backpressure with ignored beats and a flush in OUT
        step(1, 4'h3, 0, 1); step(1, 4'h0, 0, 1); step(1, 4'h0, 0, 1); step(1, 4'h0, 0, 0);
        step(1, 4'h5, 0, 0); step(1, 4'h5, 1, 0); step(1, 4'h5, 0, 0);
        chk("stall_data", 32'(out_data), ROT ? 32'h9 : 32'h3);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        step(0, 4'h0, 0, 1);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_data_kept", 32'(out_data), ROT ? 32'h9 : 32'h3);

        // Flush mid-fold, with a discarded beat
        step(1, 4'h1, 0, 1); step(1, 4'h2, 0, 1); step(1, 4'h7, 1, 1);
        step(1, 4'h3, 0, 1); step(1, 4'h0, 0, 1); step(1, 4'h0, 0, 1); step(1, 4'h0, 0, 1);
        chk("flush_fold", 32'(out_data), ROT ? 32'h9 : 32'h3);
        step(0, 4'h0, 0, 1);

        // Reset mid-fold
        step(1, 4'h6, 0, 1); step(1, 4'h9, 0, 1);
        reset_pulse("midrst");
        step(1, 4'hA, 0, 1); step(1, 4'h0, 0, 1); step(1, 4'h0, 0, 1); step(1, 4'h0, 0, 1);
        chk("rst_refold", 32'(out_data), ROT ? 32'h5 : 32'hA);
        step(0, 4'h0, 0, 1);

        // Randomized traffic against the reference
        d = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if (!m_busy) d = 4'($urandom);
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 2) != 0);
        end

        // WIDTH=1, BEATS=2 instance
        in_valid1 = 1'b1; in_data1 = 1'b1; step(0, 4'h0, 0, 1);
        chk("w1_not_early", 32'(out_valid1), 32'd0);
        in_data1 = 1'b1; step(0, 4'h0, 0, 1);
        chk("w1_fold_11_valid", 32'(out_valid1), 32'd1);
        chk("w1_fold_11", 32'(out_data1), 32'd0);
        in_valid1 = 1'b0; step(0, 4'h0, 0, 1);
        chk("w1_release", 32'(out_valid1), 32'd0);
        in_valid1 = 1'b1; in_data1 = 1'b1; step(0, 4'h0, 0, 1);
        in_data1 = 1'b0; step(0, 4'h0, 0, 1);
        chk("w1_fold_10_valid", 32'(out_valid1), 32'd1);
        chk("w1_fold_10", 32'(out_data1), 32'd1);
        in_valid1 = 1'b0; step(0, 4'h0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xor_fold_acc.md
# xor_fold_acc

- Sequential consumer for the bit-sliced vector datapaths (permute, mux, gated-XOR stages).
- Accepts WIDTH-bit beats over a valid/ready handshake and folds BEATS consecutive beats into one WIDTH-bit result by lane-wise XOR.
- Presents the result on a registered valid/ready output.
- Provides a sequential, multi-cycle target for the vectorization pass: identical per-lane logic plus shared control.

## Interface
- WIDTH, 4, data lane count (>=1)
- BEATS, 4, beats folded per result (>=2)
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of a partial fold
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block accepts a beat
- in_data  input  WIDTH  beat data
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  folded result

## Operation
- Two states:
  - ACC: accumulating; in_ready=1, out_valid=0.
  - OUT: result held; in_ready=0, out_valid=1.
- in_ready is combinational from state only: 1 in ACC, 0 in OUT.
- Beat accepted when in_valid && in_ready. The accept always updates the accumulator; the final beat also ends the fold:
  - Every accept: acc <= m(acc) ^ in_data and cnt <= cnt+1.
  - m is identity, or rotate-left-by-1 under the configuration macro.
- Final beat is the accept with cnt==BEATS-1. On that edge:
  - out_data <= m(acc)^in_data;
  - acc <= 0, cnt <= 0;
  - state -> OUT.
- OUT: when out_ready=1, state -> ACC on that edge; out_data is kept unchanged.
- flush in ACC: acc <= 0 and cnt <= 0; a beat in the same cycle is consumed (handshake completes) and discarded.
- flush in OUT: ignored; the held result is unaffected.
- cnt is $clog2(BEATS) bits wide. It wraps only via the final-beat clear, never arithmetically.
- Upstream must hold in_data stable while in_valid=1 and in_ready=0. in_valid may drop at any time.

## Timing
- Reset (rst_n low, asynchronous): state=ACC, acc=0, cnt=0, out_data=0, out_valid=0, in_ready=1.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: at most one result per BEATS+1 cycles. The OUT→ACC cycle cannot also accept a beat.
- out_data and out_valid are registered and stable while out_valid=1 and out_ready=0.
- Reset mid-fold discards the partial fold and any held result; the block restarts with cnt=0.
- Back-to-back beats with in_valid held high are accepted every cycle in ACC.

## Configuration
- XOR_FOLD_ROTATE_EN defined:
  - m(acc) = {acc[WIDTH-2:0], acc[WIDTH-1]}, i.e. rotate left by 1 before each XOR.
  - For WIDTH=1, m is identity.
- Undefined: m(acc)=acc, a plain XOR fold.
- Interface and timing are identical in both builds.

## Structure
- Package xor_fold_pkg:
  - state typedef enum logic {ACC, OUT};
  - function rotl1 parameterized by width via a WIDTH-generic helper or macro.
- No sub-module: per-lane XOR and rotation are inline; control is one FSM plus the counter.

## Test plan
WIDTH=4, BEATS=4 unless stated.
- Plain fold: no macro, beats 4'h1,4'h2,4'h4,4'h8 back-to-back, out_ready=1 -> out_data=4'hF, out_valid high one cycle, one cycle after the 4th accept.
- Rotate build: XOR_FOLD_ROTATE_EN, same beats -> out_data=4'h0. Beats 4'h3,0,0,0 -> out_data=4'h9.
- Backpressure: out_ready=0 for 3 cycles after result -> out_valid=1, out_data stable, in_ready=0, in_valid ignored; out_ready=1 -> in_ready=1 next cycle.
- Flush mid-fold:
  - Sequence: beats 4'h1, 4'h2, flush (with a beat 4'h7 in the same cycle), then 4'h3,0,0,0.
  - Expected: out_data=4'h3 without macro, 4'h9 with it.
  - Flush in OUT leaves the held result unchanged.
- Reset mid-fold: 2 beats accepted, rst_n low 1 cycle -> out_valid=0, out_data=0. Then beats 4'hA,0,0,0 -> out_data=4'hA (no macro).
- BEATS=2, WIDTH=1: beats 1,1 -> out_data=0; beats 1,0 -> out_data=1 (both builds).
